// File: rtl/key_led_status_ctrl.sv
// key_led_status_ctrl: debounced key presses select a severity blink pattern shown on an LED row
module key_led_status_ctrl #(
  parameter int          NB_KEY      = 4,
  parameter int          WD_LED      = 4,
  parameter int          WD_INFO     = 4,
  parameter logic        MD_PRESS    = 1'b0,
  parameter logic        MD_LIGHT    = 1'b0,
  parameter logic [19:0] NB_DEBOUNCE = 20'd1_000_000,
  parameter logic [31:0] NB_DLY      = 32'd1_000_000_000,
  parameter logic [4:0]  NB_FAST     = 5'd24,
  parameter logic [4:0]  NB_SLOW     = 5'd26
) (
  input  logic                      i_sys_clk,
  input  logic                      i_rst_n,
  input  logic [NB_KEY-1:0]         i_key_row,
  input  logic [NB_KEY*WD_INFO-1:0] i_info_data,
  input  logic                      i_clr,
  output logic [WD_LED-1:0]         o_led_row,
  output logic                      o_busy,
  output logic [$clog2(NB_KEY):0]   o_key_idx,
  output logic [WD_INFO-1:0]        o_info_code
);
  localparam int WD_IDX = $clog2(NB_KEY) + 1;
  localparam logic [NB_KEY-1:0] REL = {NB_KEY{~MD_PRESS}};
  typedef enum logic [2:0] {IDLE, WAIT_KEY, LATCH, SHOW, HOLD_REL} state_t;
  state_t state_q, state_d;
  logic [NB_KEY-1:0] sync1_q, sync2_q, prev_q, deb_q, deb_d, press_evt;
  logic [19:0] cnt_q, cnt_d;
  logic [31:0] timer_q, timer_d;
  logic [WD_IDX-1:0] idx_q, idx_d, sel_idx;
  logic [WD_INFO-1:0] code_q, code_d, sel_code;
  logic [WD_LED-1:0] led_q, led_d, lit;
  logic [1:0] sev_d;
  logic chg, any_evt, take, busy_q, busy_d;

  function automatic logic [1:0] sev(input logic [WD_INFO-1:0] c);
    return int'(c) == 1 ? 2'd1 : int'(c) == 2 ? 2'd2 : 2'd0;
  endfunction

  always_comb begin
    chg = sync2_q != prev_q;
    cnt_d = chg ? '0 : (cnt_q == NB_DEBOUNCE - 20'd1 ? cnt_q : cnt_q + 20'd1);
    deb_d = (!chg && cnt_q == NB_DEBOUNCE - 20'd1) ? sync2_q : deb_q;
    press_evt = (deb_d ^ REL) & ~(deb_q ^ REL);
    any_evt = |press_evt;
    sel_idx = '0;
    for (int k = NB_KEY - 1; k >= 0; k--) sel_idx = press_evt[k] ? WD_IDX'(k) : sel_idx;
    sel_code = i_info_data[sel_idx * WD_INFO +: WD_INFO];
    // preemption needs strictly higher severity; a clear always wins
    take = any_evt && !i_clr && (state_q == WAIT_KEY || (state_q == SHOW && sev(sel_code) > sev(code_q)));
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = WAIT_KEY;
      WAIT_KEY: state_d = take ? LATCH : WAIT_KEY;
      LATCH:    state_d = i_clr ? HOLD_REL : SHOW;
      SHOW:     state_d = i_clr ? HOLD_REL : take ? LATCH : (timer_q == NB_DLY - 32'd1) ? HOLD_REL : SHOW;
      HOLD_REL: state_d = deb_q == REL ? WAIT_KEY : HOLD_REL;
      default:  state_d = IDLE;
    endcase
    idx_d = take ? sel_idx : idx_q;
    code_d = take ? sel_code : code_q;
    timer_d = (state_q == SHOW && state_d == SHOW) ? timer_q + 32'd1 : '0;
    busy_d = state_d == LATCH || state_d == SHOW;
    sev_d = sev(code_d);
    lit = '0;
    lit[0] = state_d == WAIT_KEY || (state_d == SHOW && timer_d[NB_SLOW]);
    lit[1] = busy_d;
    lit[2] = state_d == SHOW && (sev_d == 2'd2 ? timer_d[NB_FAST] : timer_d[NB_SLOW]);
    lit[3] = state_d == SHOW && (sev_d == 2'd0 ? timer_d[NB_SLOW] : timer_d[NB_FAST]);
    for (int i = 4; i < WD_LED; i++) lit[i] = busy_d && int'(idx_d) == i - 4;
    led_d = lit ^ {WD_LED{~MD_LIGHT}};
  end

  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_n) begin
      sync1_q <= REL;
      sync2_q <= REL;
      prev_q  <= REL;
      deb_q   <= REL;
      cnt_q   <= '0;
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      code_q  <= '0;
      busy_q  <= 1'b0;
      led_q   <= {WD_LED{~MD_LIGHT}};
    end else begin
      sync1_q <= i_key_row;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      code_q  <= code_d;
      busy_q  <= busy_d;
      led_q   <= led_d;
    end
  end

  assign o_led_row   = led_q;
  assign o_busy      = busy_q;
  assign o_key_idx   = idx_q;
  assign o_info_code = code_q;
endmodule
